// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture path.
package cam_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W_DEFAULT  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        ARMED   = 3'd2,
        CAPTURE = 3'd3,
        DROP    = 3'd4
    } cam_state_t;

    // Shift one byte into the packer; lsb_first places the first byte in [7:0].
    function automatic logic [31:0] shift_byte(input logic [31:0] w,
                                               input logic [7:0]  b,
                                               input logic        lsb_first);
        return lsb_first ? {b, w[31:8]} : {w[23:0], b};
    endfunction

endpackage

// File: rtl/cam_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-high reset.
module cam_sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments make both flops sample pre-edge values, so d_i takes exactly two edges to reach q_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cam_pixel_packer.sv
// Camera byte-to-word packer: frame-aligned capture, FIFO push, drop-on-full and statistics.
module cam_pixel_packer
    import cam_pkg::*;
#(
    parameter int unsigned BYTE_ORDER = 0,
    parameter int unsigned LINE_FLUSH = 1,
    parameter logic [7:0]  PAD_BYTE   = 8'h00,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic             PCLKI,
    input  logic             WBs_RST_i,
    input  logic             VSYNCI,
    input  logic             HREFI,
    input  logic [7:0]       CAM_D_i,
    input  logic             capture_en_i,
    input  logic             fifo_full_i,
    output logic             push_o,
    output logic [31:0]      data_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] line_cnt_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam logic LSB_FIRST = (BYTE_ORDER != 0);
    localparam logic FLUSH     = (LINE_FLUSH != 0);

    logic             en_s;
    cam_state_t       state_q, state_d;
    logic             vsync_q, href_q;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             push_q, push_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] line_q, line_d;
    logic [CNT_W-1:0] word_q, word_d;
    logic             ovf_q, ovf_d;

    logic        vld, vsync_rise, vsync_fall, href_rise, href_fall;
    logic        word_ready;
    logic [31:0] word_val;

    cam_sync_2ff u_en_sync (
        .clk_i (PCLKI),
        .rst_i (WBs_RST_i),
        .d_i   (capture_en_i),
        .q_o   (en_s)
    );

    // Fill the unused byte positions of a partial word with PAD_BYTE.
    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [1:0] n);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
            if (i + int'(n) < BYTES_PER_WORD) r = shift_byte(r, PAD_BYTE, LSB_FIRST);
        end
        return r;
    endfunction

    assign vld        = HREFI & VSYNCI;
    assign vsync_rise = VSYNCI & ~vsync_q;
    assign vsync_fall = ~VSYNCI & vsync_q;
    assign href_rise  = HREFI & ~href_q;
    assign href_fall  = ~HREFI & href_q;

    // NOTE: every _d takes its hold value first, so no branch below can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        push_d     = 1'b0;
        data_d     = data_q;
        frame_d    = frame_q;
        line_d     = line_q;
        word_d     = word_q;
        ovf_d      = ovf_q;
        word_ready = 1'b0;
        word_val   = '0;

        case (state_q)
            IDLE: begin
                if (en_s) state_d = SYNC;
            end
            SYNC: begin
                if (!en_s)        state_d = IDLE;
                else if (!VSYNCI) state_d = ARMED;
            end
            ARMED: begin
                if (!en_s) begin
                    state_d = IDLE;
                end else if (vsync_rise) begin
                    state_d    = CAPTURE;
                    line_d     = '0;
                    word_d     = '0;
                    byte_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            CAPTURE: begin
                if (href_rise) line_d = line_q + CNT_W'(1);
                if (vld) begin
                    shreg_d    = shift_byte(shreg_q, CAM_D_i, LSB_FIRST);
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                        word_ready = 1'b1;
                        word_val   = shreg_d;
                    end
                end else if ((href_fall || vsync_fall) && byte_cnt_q != 2'd0) begin
                    byte_cnt_d = '0;
                    if (FLUSH) begin
                        word_ready = 1'b1;
                        word_val   = pad_word(shreg_q, byte_cnt_q);
                    end
                end
                if (word_ready) begin
                    if (!fifo_full_i) begin
                        push_d = 1'b1;
                        data_d = word_val;
                        word_d = word_q + CNT_W'(1);
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = DROP;
                    end
                end
                // Frame end outranks the drop transition taken on the same edge.
                if (vsync_fall) begin
                    frame_d = frame_q + CNT_W'(1);
                    state_d = en_s ? ARMED : IDLE;
                end
            end
            DROP: begin
                if (href_rise) line_d = line_q + CNT_W'(1);
                if (vsync_fall) begin
                    frame_d = frame_q + CNT_W'(1);
                    state_d = en_s ? ARMED : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q    <= IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            push_q     <= 1'b0;
            data_q     <= '0;
            frame_q    <= '0;
            line_q     <= '0;
            word_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= VSYNCI;
            href_q     <= HREFI;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            push_q     <= push_d;
            data_q     <= data_d;
            frame_q    <= frame_d;
            line_q     <= line_d;
            word_q     <= word_d;
            ovf_q      <= ovf_d;
        end
    end

    assign push_o      = push_q;
    assign data_o      = data_q;
    assign frame_cnt_o = frame_q;
    assign line_cnt_o  = line_q;
    assign word_cnt_o  = word_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = (state_q == ARMED) || (state_q == CAPTURE) || (state_q == DROP);

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench: three packer instances (default, LSB-first, no-flush) driven by one stimulus stream.
module tb_cam_pixel_packer;

    logic       PCLKI = 1'b0;
    logic       WBs_RST_i = 1'b1;
    logic       VSYNCI = 1'b0;
    logic       HREFI = 1'b0;
    logic [7:0] CAM_D_i = 8'h00;
    logic       capture_en_i = 1'b0;
    logic       fifo_full_i = 1'b0;

    logic        push_w  [3];
    logic [31:0] data_w  [3];
    logic [15:0] frame_w [3];
    logic [15:0] line_w  [3];
    logic [15:0] word_w  [3];
    logic        ovf_w   [3];
    logic        busy_w  [3];

    int n_tests = 0;
    int n_fail  = 0;
    int n_push [3] = '{0, 0, 0};
    int snap   [3];

    always #5 PCLKI = ~PCLKI;

    cam_pixel_packer #(.BYTE_ORDER(0), .LINE_FLUSH(1)) dut0 (
        .PCLKI(PCLKI), .WBs_RST_i(WBs_RST_i), .VSYNCI(VSYNCI), .HREFI(HREFI), .CAM_D_i(CAM_D_i),
        .capture_en_i(capture_en_i), .fifo_full_i(fifo_full_i), .push_o(push_w[0]), .data_o(data_w[0]),
        .frame_cnt_o(frame_w[0]), .line_cnt_o(line_w[0]), .word_cnt_o(word_w[0]),
        .overflow_o(ovf_w[0]), .busy_o(busy_w[0]));

    cam_pixel_packer #(.BYTE_ORDER(1), .LINE_FLUSH(1)) dut1 (
        .PCLKI(PCLKI), .WBs_RST_i(WBs_RST_i), .VSYNCI(VSYNCI), .HREFI(HREFI), .CAM_D_i(CAM_D_i),
        .capture_en_i(capture_en_i), .fifo_full_i(fifo_full_i), .push_o(push_w[1]), .data_o(data_w[1]),
        .frame_cnt_o(frame_w[1]), .line_cnt_o(line_w[1]), .word_cnt_o(word_w[1]),
        .overflow_o(ovf_w[1]), .busy_o(busy_w[1]));

    cam_pixel_packer #(.BYTE_ORDER(0), .LINE_FLUSH(0)) dut2 (
        .PCLKI(PCLKI), .WBs_RST_i(WBs_RST_i), .VSYNCI(VSYNCI), .HREFI(HREFI), .CAM_D_i(CAM_D_i),
        .capture_en_i(capture_en_i), .fifo_full_i(fifo_full_i), .push_o(push_w[2]), .data_o(data_w[2]),
        .frame_cnt_o(frame_w[2]), .line_cnt_o(line_w[2]), .word_cnt_o(word_w[2]),
        .overflow_o(ovf_w[2]), .busy_o(busy_w[2]));

    always @(negedge PCLKI) begin
        for (int k = 0; k < 3; k++) if (push_w[k] === 1'b1) n_push[k]++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic v, input logic h, input logic [7:0] d);
        @(negedge PCLKI);
        VSYNCI  = v;
        HREFI   = h;
        CAM_D_i = d;
        @(posedge PCLKI);
        #1;
    endtask

    task automatic gap(input logic v, input int n);
        for (int i = 0; i < n; i++) cyc(v, 1'b0, 8'h00);
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] b;
        b = base;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b1, b);
            b = b + step;
        end
    endtask

    task automatic take_snap();
        for (int k = 0; k < 3; k++) snap[k] = n_push[k];
    endtask

    task automatic frame_start();
        gap(1'b0, 2);
        cyc(1'b1, 1'b0, 8'h00);
        gap(1'b1, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge PCLKI);
        #1;
        check("rst_push",  32'(push_w[0]),  32'h0);
        check("rst_data",  data_w[0],       32'h0);
        check("rst_frame", 32'(frame_w[0]), 32'h0);
        check("rst_line",  32'(line_w[0]),  32'h0);
        check("rst_word",  32'(word_w[0]),  32'h0);
        check("rst_ovf",   32'(ovf_w[0]),   32'h0);
        check("rst_busy",  32'(busy_w[0]),  32'h0);
        WBs_RST_i = 1'b0;

        // Packing: 8 bytes 11..88 in one line
        capture_en_i = 1'b1;
        gap(1'b0, 6);
        check("arm_busy", 32'(busy_w[0]), 32'h1);
        take_snap();
        cyc(1'b1, 1'b0, 8'h00);
        gap(1'b1, 2);
        send_bytes(4, 8'h11, 8'h11);
        check("pk_w0_push", 32'(push_w[0]), 32'h1);
        check("pk_w0_be",   data_w[0], 32'h11223344);
        check("pk_w0_le",   data_w[1], 32'h44332211);
        send_bytes(1, 8'h55, 8'h00);
        check("pk_push_gap", 32'(push_w[0]), 32'h0);
        send_bytes(3, 8'h66, 8'h11);
        check("pk_w1_push", 32'(push_w[0]), 32'h1);
        check("pk_w1_be",   data_w[0], 32'h55667788);
        check("pk_w1_le",   data_w[1], 32'h88776655);
        cyc(1'b1, 1'b0, 8'h00);
        check("pk_hold_data", data_w[0], 32'h55667788);
        gap(1'b1, 2);
        cyc(1'b0, 1'b0, 8'h00);
        check("pk_frame", 32'(frame_w[0]), 32'h1);
        check("pk_line",  32'(line_w[0]),  32'h1);
        check("pk_word",  32'(word_w[0]),  32'h2);
        check("pk_word_le", 32'(word_w[1]), 32'h2);
        check("pk_npush", 32'(n_push[0] - snap[0]), 32'h2);

        // Partial line: 6 bytes A1..A6
        take_snap();
        frame_start();
        send_bytes(4, 8'hA1, 8'h01);
        check("pl_w0_flush",   data_w[0], 32'hA1A2A3A4);
        check("pl_w0_noflush", data_w[2], 32'hA1A2A3A4);
        send_bytes(2, 8'hA5, 8'h01);
        cyc(1'b1, 1'b0, 8'h00);
        check("pl_pad_push",    32'(push_w[0]), 32'h1);
        check("pl_pad_be",      data_w[0], 32'hA5A60000);
        check("pl_pad_le",      data_w[1], 32'h0000A6A5);
        check("pl_nf_no_push",  32'(push_w[2]), 32'h0);
        gap(1'b1, 1);
        cyc(1'b0, 1'b0, 8'h00);
        check("pl_word_flush",   32'(word_w[0]),  32'h2);
        check("pl_word_noflush", 32'(word_w[2]),  32'h1);
        check("pl_frame",        32'(frame_w[0]), 32'h2);
        check("pl_npush_nf",     32'(n_push[2] - snap[2]), 32'h1);

        // Mid-frame enable: frame already running when enable arrives
        capture_en_i = 1'b0;
        gap(1'b0, 4);
        check("dis_idle", 32'(busy_w[0]), 32'h0);
        take_snap();
        cyc(1'b1, 1'b0, 8'h00);
        gap(1'b1, 1);
        capture_en_i = 1'b1;
        gap(1'b1, 5);
        send_bytes(4, 8'hB1, 8'h01);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("me_no_push", 32'(n_push[0] - snap[0]), 32'h0);
        check("me_frame",   32'(frame_w[0]), 32'h2);
        check("me_armed",   32'(busy_w[0]),  32'h1);
        frame_start();
        send_bytes(4, 8'h01, 8'h01);
        check("me_next_data", data_w[0], 32'h01020304);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("me_next_frame", 32'(frame_w[0]), 32'h3);

        // Overflow: FIFO full at the 2nd word of a 3-line frame
        take_snap();
        frame_start();
        send_bytes(4, 8'h10, 8'h01);
        cyc(1'b1, 1'b0, 8'h00);
        gap(1'b1, 1);
        send_bytes(3, 8'h20, 8'h01);
        fifo_full_i = 1'b1;
        send_bytes(1, 8'h23, 8'h00);
        fifo_full_i = 1'b0;
        check("ov_no_push", 32'(push_w[0]), 32'h0);
        check("ov_flag",    32'(ovf_w[0]),  32'h1);
        cyc(1'b1, 1'b0, 8'h00);
        gap(1'b1, 1);
        send_bytes(4, 8'h30, 8'h01);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("ov_npush",  32'(n_push[0] - snap[0]), 32'h1);
        check("ov_line",   32'(line_w[0]),  32'h3);
        check("ov_word",   32'(word_w[0]),  32'h1);
        check("ov_frame",  32'(frame_w[0]), 32'h4);
        check("ov_sticky", 32'(ovf_w[0]),   32'h1);
        gap(1'b0, 2);
        cyc(1'b1, 1'b0, 8'h00);
        check("ov_clear", 32'(ovf_w[0]), 32'h0);
        gap(1'b1, 1);
        send_bytes(4, 8'h40, 8'h01);
        check("ov_next_data", data_w[0], 32'h40414243);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("ov_next_frame", 32'(frame_w[0]), 32'h5);
        check("ov_next_word",  32'(word_w[0]),  32'h1);

        // Disable mid-frame: frame completes, then IDLE
        take_snap();
        frame_start();
        send_bytes(4, 8'h50, 8'h01);
        cyc(1'b1, 1'b0, 8'h00);
        capture_en_i = 1'b0;
        gap(1'b1, 1);
        send_bytes(4, 8'h54, 8'h01);
        check("ds_last_data", data_w[0], 32'h54555657);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("ds_npush", 32'(n_push[0] - snap[0]), 32'h2);
        check("ds_frame", 32'(frame_w[0]), 32'h6);
        check("ds_idle",  32'(busy_w[0]),  32'h0);
        take_snap();
        frame_start();
        send_bytes(4, 8'h60, 8'h01);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("ds_next_npush", 32'(n_push[0] - snap[0]), 32'h0);
        check("ds_next_frame", 32'(frame_w[0]), 32'h6);

        // Reset after 2 bytes of a word
        capture_en_i = 1'b1;
        gap(1'b0, 6);
        cyc(1'b1, 1'b0, 8'h00);
        gap(1'b1, 1);
        send_bytes(2, 8'h70, 8'h01);
        take_snap();
        #2;
        WBs_RST_i = 1'b1;
        #1;
        check("mr_push",  32'(push_w[0]),  32'h0);
        check("mr_data",  data_w[0],       32'h0);
        check("mr_frame", 32'(frame_w[0]), 32'h0);
        check("mr_word",  32'(word_w[0]),  32'h0);
        check("mr_line",  32'(line_w[0]),  32'h0);
        check("mr_busy",  32'(busy_w[0]),  32'h0);
        send_bytes(1, 8'h72, 8'h00);
        WBs_RST_i = 1'b0;
        send_bytes(4, 8'h73, 8'h01);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("mr_no_push",  32'(n_push[0] - snap[0]), 32'h0);
        check("mr_frame_hd", 32'(frame_w[0]), 32'h0);
        frame_start();
        send_bytes(4, 8'h80, 8'h01);
        check("mr_resume_data", data_w[0], 32'h80818283);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("mr_resume_frame", 32'(frame_w[0]), 32'h1);
        check("mr_resume_word",  32'(word_w[0]),  32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
